uarc_link: RTL and testbench

UARC_LINK -- requirements
Module: uarc_link

---
 rtl/uarc_pkg.sv | 20 ++
 rtl/uarc_fifo.sv | 55 +++++
 rtl/uarc_link.sv | 117 +++++++++++
 tb/tb_uarc_link.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uarc_pkg.sv
// Shared types for the uarc link: controller state and the queued message layout.
package uarc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_INCEPT = 2'd2,
        ST_KILL   = 2'd3
    } uarc_state_t;

    localparam int UARC_WORD_MAG = 5;

    // Message FIFO entry at the default word width; the link packs its entries
    // in the same order (is_stream in the MSB, data below it).
    typedef struct packed {
        logic                            is_stream;
        logic [(1<<UARC_WORD_MAG)-1:0]   data;
    } uarc_entry_t;

endpackage

// File: rtl/uarc_fifo.sv
// Message FIFO for the uarc link: power-of-two depth, a flush port, and a head
// word that is shown straight out of storage.
module uarc_fifo #(
    parameter int WIDTH     = 33,
    parameter int DEPTH_MAG = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic                 i_flush,
    input  logic [WIDTH-1:0]     i_din,
    output logic [WIDTH-1:0]     o_head,
    output logic [DEPTH_MAG:0]   o_count,
    output logic                 o_full,
    output logic                 o_empty
);
    localparam int DEPTH = 1 << DEPTH_MAG;

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [DEPTH_MAG-1:0] r_wr;
    logic [DEPTH_MAG-1:0] r_rd;
    logic [DEPTH_MAG:0]   r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_full    = (r_count == (DEPTH_MAG+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd];
    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign w_do_push = i_push & ~o_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr] <= i_din;
    end

endmodule

// File: rtl/uarc_link.sv
// Point-to-point message link: arbitrates sender requests, queues send/stream
// words, and sequences incept (after draining) and kill (after flushing).
module uarc_link #(
    parameter int WORD_MAG = 5,
    parameter int FIFO_MAG = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sender_enable,
    input  logic                        sender_kill,
    input  logic                        sender_incept,
    input  logic                        sender_send,
    input  logic                        sender_stream,
    input  logic [(1<<WORD_MAG)-1:0]    sender_data,
    input  logic [(1<<WORD_MAG)-1:0]    sender_incept_permission,
    input  logic [(1<<WORD_MAG)-1:0]    sender_incept_address,
    output logic                        sender_kill_ack,
    output logic                        sender_incept_ack,
    output logic                        sender_send_ack,
    output logic                        sender_stream_ack,
    input  logic                        receiver_enable,
    output logic                        receiver_kill,
    output logic                        receiver_incept,
    output logic                        receiver_send,
    output logic                        receiver_stream,
    output logic [(1<<WORD_MAG)-1:0]    receiver_data,
    output logic [(1<<WORD_MAG)-1:0]    receiver_incept_permission,
    output logic [(1<<WORD_MAG)-1:0]    receiver_incept_address,
    input  logic                        receiver_kill_ack,
    input  logic                        receiver_incept_ack,
    input  logic                        receiver_send_ack,
    input  logic                        receiver_stream_ack,
    output logic [FIFO_MAG:0]           fifo_count
);
    import uarc_pkg::*;

    localparam int W = 1 << WORD_MAG;

    uarc_state_t r_state;
    logic [W-1:0] r_perm;
    logic [W-1:0] r_addr;

    logic [W:0]   w_head;
    logic         w_full;
    logic         w_empty;
    logic         w_push;
    logic         w_pop;
    logic         w_idle;
    logic         w_deliver;
    logic         w_win_kill;
    logic         w_win_incept;
    logic         w_win_send;
    logic         w_win_stream;

    assign w_win_kill   = sender_enable & sender_kill;
    assign w_win_incept = sender_enable & ~sender_kill & sender_incept;
    assign w_win_send   = sender_enable & ~sender_kill & ~sender_incept & sender_send;
    assign w_win_stream = sender_enable & ~sender_kill & ~sender_incept & ~sender_send & sender_stream;
    assign w_idle       = (r_state == ST_IDLE);

    // Every ack and request is qualified by reset so nothing leaks while it is low.
    assign sender_kill_ack   = reset & w_win_kill & (r_state != ST_KILL);
    assign sender_incept_ack = reset & w_win_incept & w_idle;
    assign sender_send_ack   = reset & w_win_send & w_idle & ~w_full;
    assign sender_stream_ack = reset & w_win_stream & w_idle & ~w_full;
    assign w_push            = sender_send_ack | sender_stream_ack;

    assign w_deliver       = reset & receiver_enable & ~w_empty & (w_idle | (r_state == ST_DRAIN));
    assign receiver_send   = w_deliver & ~w_head[W];
    assign receiver_stream = w_deliver & w_head[W];
    assign receiver_data   = w_deliver ? w_head[W-1:0] : '0;
    assign w_pop           = (receiver_send & receiver_send_ack) | (receiver_stream & receiver_stream_ack);

    assign receiver_incept            = reset & receiver_enable & (r_state == ST_INCEPT);
    assign receiver_incept_permission = receiver_incept ? r_perm : '0;
    assign receiver_incept_address    = receiver_incept ? r_addr : '0;
    assign receiver_kill              = reset & receiver_enable & (r_state == ST_KILL);

    uarc_fifo #(
        .WIDTH     (W + 1),
        .DEPTH_MAG (FIFO_MAG)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (sender_kill_ack),
        .i_din   ({sender_stream_ack, sender_data}),
        .o_head  (w_head),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_perm  <= '0;
            r_addr  <= '0;
        end else if (sender_kill_ack) begin
            r_state <= ST_KILL;
        end else begin
            case (r_state)
                ST_IDLE: if (sender_incept_ack) begin
                    r_state <= ST_DRAIN;
                    r_perm  <= sender_incept_permission;
                    r_addr  <= sender_incept_address;
                end
                ST_DRAIN:  if (w_empty) r_state <= ST_INCEPT;
                ST_INCEPT: if (receiver_incept & receiver_incept_ack) r_state <= ST_IDLE;
                ST_KILL:   if (receiver_kill & receiver_kill_ack) r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uarc_link.sv
// Bench for uarc_link: directed scenarios plus random traffic, all cycles checked
// against a queue-based model of the link behaviour.
module tb_uarc_link;
    import uarc_pkg::*;

    localparam int W = 32;
    localparam int D = 4;
    localparam int M_IDLE = 0, M_DRAIN = 1, M_INCEPT = 2, M_KILL = 3;

    logic clk = 1'b0;
    logic reset;
    logic sender_enable, sender_kill, sender_incept, sender_send, sender_stream;
    logic [W-1:0] sender_data, sender_incept_permission, sender_incept_address;
    logic sender_kill_ack, sender_incept_ack, sender_send_ack, sender_stream_ack;
    logic receiver_enable, receiver_kill, receiver_incept, receiver_send, receiver_stream;
    logic [W-1:0] receiver_data, receiver_incept_permission, receiver_incept_address;
    logic receiver_kill_ack, receiver_incept_ack, receiver_send_ack, receiver_stream_ack;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    uarc_link #(.WORD_MAG(5), .FIFO_MAG(2)) dut (
        .clk(clk), .reset(reset),
        .sender_enable(sender_enable), .sender_kill(sender_kill), .sender_incept(sender_incept),
        .sender_send(sender_send), .sender_stream(sender_stream), .sender_data(sender_data),
        .sender_incept_permission(sender_incept_permission), .sender_incept_address(sender_incept_address),
        .sender_kill_ack(sender_kill_ack), .sender_incept_ack(sender_incept_ack),
        .sender_send_ack(sender_send_ack), .sender_stream_ack(sender_stream_ack),
        .receiver_enable(receiver_enable), .receiver_kill(receiver_kill), .receiver_incept(receiver_incept),
        .receiver_send(receiver_send), .receiver_stream(receiver_stream), .receiver_data(receiver_data),
        .receiver_incept_permission(receiver_incept_permission), .receiver_incept_address(receiver_incept_address),
        .receiver_kill_ack(receiver_kill_ack), .receiver_incept_ack(receiver_incept_ack),
        .receiver_send_ack(receiver_send_ack), .receiver_stream_ack(receiver_stream_ack),
        .fifo_count(fifo_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    uarc_entry_t m_q[$];
    int          m_state = M_IDLE;
    logic [W-1:0] m_perm = '0, m_addr = '0;

    logic o_kack, o_iack, o_sack, o_tack, o_rsend, o_rstream, o_rinc, o_rkill;
    logic [W-1:0] o_rdata, o_perm, o_addr;
    logic [2:0] o_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic cyc();
        bit rn, ka, ia, sa, ta, dl, es, et, ei, ek, pop;
        logic [W-1:0] ed;
        uarc_entry_t e;
        #1;
        rn = reset;
        ka = rn && sender_enable && sender_kill && m_state != M_KILL;
        ia = rn && sender_enable && !sender_kill && sender_incept && m_state == M_IDLE;
        sa = rn && sender_enable && !sender_kill && !sender_incept && sender_send
             && m_state == M_IDLE && m_q.size() < D;
        ta = rn && sender_enable && !sender_kill && !sender_incept && !sender_send && sender_stream
             && m_state == M_IDLE && m_q.size() < D;
        dl = rn && receiver_enable && (m_state == M_IDLE || m_state == M_DRAIN) && m_q.size() > 0;
        es = 0; et = 0; ed = '0;
        if (dl) begin
            es = !m_q[0].is_stream;
            et = m_q[0].is_stream;
            ed = m_q[0].data;
        end
        ei = rn && receiver_enable && m_state == M_INCEPT;
        ek = rn && receiver_enable && m_state == M_KILL;
        o_kack = sender_kill_ack; o_iack = sender_incept_ack;
        o_sack = sender_send_ack; o_tack = sender_stream_ack;
        o_rsend = receiver_send; o_rstream = receiver_stream; o_rdata = receiver_data;
        o_rinc = receiver_incept; o_perm = receiver_incept_permission;
        o_addr = receiver_incept_address; o_rkill = receiver_kill; o_cnt = fifo_count;
        chk("kill_ack", o_kack, ka);
        chk("incept_ack", o_iack, ia);
        chk("send_ack", o_sack, sa);
        chk("stream_ack", o_tack, ta);
        chk("rx_send", o_rsend, es);
        chk("rx_stream", o_rstream, et);
        chk("rx_data", o_rdata, ed);
        chk("rx_incept", o_rinc, ei);
        chk("rx_perm", o_perm, ei ? m_perm : '0);
        chk("rx_addr", o_addr, ei ? m_addr : '0);
        chk("rx_kill", o_rkill, ek);
        chk("fifo_count", o_cnt, m_q.size());
        pop = (es && receiver_send_ack) || (et && receiver_stream_ack);
        @(posedge clk);
        if (!rn) begin
            m_q.delete(); m_state = M_IDLE; m_perm = '0; m_addr = '0;
        end else if (ka) begin
            m_q.delete(); m_state = M_KILL;
        end else begin
            case (m_state)
                M_DRAIN:  if (m_q.size() == 0) m_state = M_INCEPT;
                M_INCEPT: if (ei && receiver_incept_ack) m_state = M_IDLE;
                M_KILL:   if (ek && receiver_kill_ack) m_state = M_IDLE;
                default:  if (ia) begin
                    m_state = M_DRAIN; m_perm = sender_incept_permission; m_addr = sender_incept_address;
                end
            endcase
            if (pop) void'(m_q.pop_front());
            if (sa || ta) begin
                e.is_stream = ta; e.data = sender_data;
                m_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_in();
        reset = 1; sender_enable = 1; sender_kill = 0; sender_incept = 0; sender_send = 0;
        sender_stream = 0; sender_data = '0; sender_incept_permission = '0; sender_incept_address = '0;
        receiver_enable = 1; receiver_kill_ack = 0; receiver_incept_ack = 0;
        receiver_send_ack = 0; receiver_stream_ack = 0;
    endtask

    task automatic do_reset();
        idle_in(); reset = 0; cyc(); reset = 1;
    endtask

    task automatic push_sends(input int n);
        sender_send = 1;
        for (int i = 0; i < n; i++) begin
            sender_data = 32'h1000 + i; cyc();
        end
        sender_send = 0;
    endtask

    initial begin
        logic [W-1:0] vals [3];
        int pops;
        bit seen;
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        idle_in(); reset = 0;
        @(posedge clk); @(negedge clk);
        do_reset();
        chk("reset_cnt", o_cnt, 0);
        chk("reset_rx", {o_rsend, o_rstream, o_rinc, o_rkill}, 0);

        // Three sends, receiver acking every cycle
        do_reset();
        receiver_send_ack = 1; sender_send = 1;
        for (int i = 0; i < 3; i++) begin
            sender_data = vals[i]; cyc();
            chk("s36_ack", o_sack, 1);
            if (i > 0) chk("s36_data", o_rdata, vals[i-1]);
        end
        sender_send = 0; cyc();
        chk("s36_last", o_rdata, vals[2]);
        cyc(); chk("s36_empty", o_cnt, 0);

        // Fill with receiver disabled, then release
        do_reset();
        receiver_enable = 0; sender_stream = 1;
        for (int i = 0; i < 5; i++) begin
            sender_data = 32'h100 + i; cyc();
            chk("s37_ack", o_tack, (i < 4));
        end
        cyc();
        chk("s37_hold", o_tack, 0);
        chk("s37_cnt", o_cnt, 4);
        receiver_enable = 1; receiver_stream_ack = 1; cyc();
        chk("s37_head", o_rdata, 32'h100);
        chk("s37_fullpop", o_tack, 0);
        cyc(); chk("s37_ack5", o_tack, 1);
        sender_stream = 0;
        for (int i = 0; i < 4; i++) cyc();
        cyc(); chk("s37_drained", o_cnt, 0);

        // Incept waits for the queue to drain
        do_reset();
        receiver_enable = 0; push_sends(2);
        sender_incept = 1; sender_incept_permission = 32'hA5; sender_incept_address = 32'h40;
        cyc(); chk("s38_iack", o_iack, 1);
        sender_incept = 0; sender_incept_permission = '0; sender_incept_address = '0;
        receiver_enable = 1; receiver_send_ack = 1;
        pops = 0; seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            cyc();
            if (o_rinc) begin
                seen = 1;
                chk("s38_pops", pops, 2);
                chk("s38_perm", o_perm, 32'hA5);
                chk("s38_addr", o_addr, 32'h40);
            end
            if (o_rsend) pops++;
        end
        chk("s38_seen", seen, 1);
        receiver_incept_ack = 1; cyc(); receiver_incept_ack = 0;
        cyc(); chk("s38_done", o_rinc, 0);

        // Kill beats a simultaneous send and flushes the queue
        do_reset();
        receiver_enable = 0; push_sends(3);
        sender_kill = 1; sender_send = 1; cyc();
        chk("s39_kack", o_kack, 1);
        chk("s39_sack", o_sack, 0);
        sender_kill = 0; sender_send = 0; cyc();
        chk("s39_flush", o_cnt, 0);
        receiver_enable = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(); chk("s39_khold", o_rkill, 1);
        end
        receiver_kill_ack = 1; cyc(); receiver_kill_ack = 0;
        cyc(); chk("s39_kdone", o_rkill, 0);

        // Reset in the middle of a drain
        do_reset();
        receiver_enable = 0; push_sends(2);
        sender_incept = 1; sender_incept_permission = 32'h77; cyc();
        sender_incept = 0; cyc();
        reset = 0; sender_send = 1; receiver_enable = 1; cyc();
        chk("s40_outs", {o_kack, o_iack, o_sack, o_tack, o_rsend, o_rstream, o_rinc, o_rkill}, 0);
        chk("s40_data", o_rdata, 0);
        reset = 1; sender_send = 0; receiver_send_ack = 1; receiver_incept_ack = 0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(); seen |= o_rinc;
        end
        chk("s40_noinc", seen, 0);
        chk("s40_cnt", o_cnt, 0);
        sender_send = 1; cyc(); chk("s40_idle", o_sack, 1);

        // Random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset               = ($urandom_range(99) != 0);
            sender_enable       = ($urandom_range(99) < 85);
            sender_kill         = ($urandom_range(99) < 3);
            sender_incept       = ($urandom_range(99) < 6);
            sender_send         = ($urandom_range(99) < 40);
            sender_stream       = ($urandom_range(99) < 35);
            sender_data         = $urandom;
            sender_incept_permission = $urandom;
            sender_incept_address    = $urandom;
            receiver_enable     = ($urandom_range(99) < 70);
            receiver_kill_ack   = ($urandom_range(99) < 40);
            receiver_incept_ack = ($urandom_range(99) < 40);
            receiver_send_ack   = ($urandom_range(99) < 55);
            receiver_stream_ack = ($urandom_range(99) < 55);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
